// File: rtl/tl_ul_sram_responder.sv
// rtl/tl_ul_sram_responder.sv - TL-UL manager endpoint fronting a word-addressed SRAM
module tl_ul_sram_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h2000_0000,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [3:0]  a_size,
    input  logic [4:0]  a_source,
    input  logic [31:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    input  logic        a_corrupt,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [3:0]  d_size,
    output logic [4:0]  d_source,
    output logic        d_sink,
    output logic        d_denied,
    output logic [31:0] d_data,
    output logic        d_corrupt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int HI    = DEPTH_LOG2 + 2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] index;
    logic [3:0]            lane_mask;
    logic                  fire, is_get, is_put, size_ok, aligned, in_range, mask_ok;
    logic                  legal, data_op;
    logic                  unused_ok;

    assign unused_ok = ^a_param;

    assign a_ready = !d_valid || d_ready;
    assign fire    = a_valid && a_ready;
    assign index   = a_address[HI-1:2];
    assign is_get  = (a_opcode == 3'd4);
    assign is_put  = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign size_ok = (a_size <= 4'd2);
    // The window is aligned to its own size, so an upper-bit compare covers both bounds.
    assign in_range = (a_address[31:HI] == ADDR_BASE[31:HI]);
    assign data_op  = (a_opcode >= 3'd2) && (a_opcode <= 3'd5);

    always_comb begin
        lane_mask = 4'hF;
        aligned   = 1'b1;
        case (a_size)
            4'd0: lane_mask = 4'b0001 << a_address[1:0];
            4'd1: begin
                lane_mask = 4'b0011 << {a_address[1], 1'b0};
                aligned   = !a_address[0];
            end
            4'd2: aligned = (a_address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        mask_ok = 1'b1;
        if (a_opcode == 3'd0)
            mask_ok = (a_mask == lane_mask);
        else if (a_opcode == 3'd1)
            mask_ok = ((a_mask & ~lane_mask) == 4'h0);
    end

    assign legal = (is_get || is_put) && size_ok && aligned && in_range && mask_ok &&
                   !(is_put && a_corrupt);

    // SRAM array is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (fire && legal && is_put) begin
            for (int i = 0; i < 4; i++) begin
                if (a_mask[i])
                    mem[index][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_valid   <= 1'b0;
            d_opcode  <= 3'd0;
            d_size    <= 4'd0;
            d_source  <= 5'd0;
            d_denied  <= 1'b0;
            d_data    <= 32'd0;
            d_corrupt <= 1'b0;
        end else if (fire) begin
            d_valid   <= 1'b1;
            d_opcode  <= {2'b00, data_op};
            d_size    <= a_size;
            d_source  <= a_source;
            d_denied  <= !legal;
            d_data    <= (legal && is_get) ? mem[index] : 32'd0;
            d_corrupt <= !legal && data_op;
        end else if (d_ready) begin
            d_valid   <= 1'b0;
        end
    end

    assign d_param = 2'd0;
    assign d_sink  = 1'b0;
endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// tb/tb_tl_ul_sram_responder.sv - table-driven check of tl_ul_sram_responder
module tb_tl_ul_sram_responder;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param;
    logic [3:0]  a_size;
    logic [4:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [4:0]  d_source;
    logic        d_sink, d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    int total = 0;
    int bad   = 0;

    tl_ul_sram_responder dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
        .d_data(d_data), .d_corrupt(d_corrupt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [4:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
        logic [2:0]  e_op;
        logic        e_den;
        logic        e_cor;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] size, input logic [4:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                         input logic corrupt);
        a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
        a_address = addr; a_mask = mask; a_data = data; a_corrupt = corrupt;
        a_param = 3'd0;
    endtask

    // Drives one request at a negedge, waits for it to fire, checks the response a cycle later.
    task automatic send(input vec_t v, input string tag);
        int n;
        drive(v.op, v.size, v.src, v.addr, v.mask, v.data, v.corrupt);
        n = 0;
        while (!a_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n == 20) check({tag, " a_ready timeout"}, 32'(a_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        a_valid = 1'b0;
        check({tag, " d_valid"},   32'(d_valid),   32'd1);
        check({tag, " d_opcode"},  32'(d_opcode),  32'(v.e_op));
        check({tag, " d_denied"},  32'(d_denied),  32'(v.e_den));
        check({tag, " d_corrupt"}, 32'(d_corrupt), 32'(v.e_cor));
        check({tag, " d_data"},    d_data,         v.e_data);
        check({tag, " d_source"},  32'(d_source),  32'(v.src));
        check({tag, " d_size"},    32'(d_size),    32'(v.size));
        check({tag, " d_param"},   32'(d_param),   32'd0);
        check({tag, " d_sink"},    32'(d_sink),    32'd0);
    endtask

    initial begin
        vec_t v;
        // op size src addr mask data corrupt | e_op e_den e_cor e_data
        vecs.push_back('{3'd0, 4'd2, 5'h01, 32'h2000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{3'd4, 4'd2, 5'h02, 32'h2000_0010, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0, 1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{3'd1, 4'd0, 5'h03, 32'h2000_0011, 4'h2, 32'h0000_5500, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{3'd4, 4'd2, 5'h04, 32'h2000_0010, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0, 1'b0, 32'hDEAD_55EF});
        vecs.push_back('{3'd0, 4'd2, 5'h05, 32'h2000_0000, 4'hF, 32'h1122_3344, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{3'd4, 4'd2, 5'h1C, 32'h2000_0400, 4'hF, 32'h0,         1'b0, 3'd1, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{3'd4, 4'd2, 5'h06, 32'h2000_0000, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0, 1'b0, 32'h1122_3344});
        vecs.push_back('{3'd0, 4'd2, 5'h07, 32'h2000_0002, 4'hF, 32'hFFFF_FFFF, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{3'd2, 4'd2, 5'h08, 32'h2000_0000, 4'hF, 32'hFFFF_FFFF, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{3'd4, 4'd2, 5'h09, 32'h2000_0000, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0, 1'b0, 32'h1122_3344});
        vecs.push_back('{3'd0, 4'd2, 5'h0A, 32'h2000_03FC, 4'hF, 32'hCAFE_F00D, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{3'd4, 4'd2, 5'h0B, 32'h2000_03FC, 4'hF, 32'h0,         1'b0, 3'd1, 1'b0, 1'b0, 32'hCAFE_F00D});
        vecs.push_back('{3'd0, 4'd1, 5'h0C, 32'h2000_0004, 4'hF, 32'h0,         1'b0, 3'd0, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{3'd1, 4'd1, 5'h0D, 32'h2000_0002, 4'h4, 32'h0077_0000, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{3'd0, 4'd2, 5'h0E, 32'h2000_0000, 4'hF, 32'h0BAD_0BAD, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{3'd4, 4'd1, 5'h1F, 32'h2000_0002, 4'h3, 32'h0,         1'b0, 3'd1, 1'b0, 1'b0, 32'h1177_3344});
        vecs.push_back('{3'd4, 4'd3, 5'h0F, 32'h2000_0000, 4'hF, 32'h0,         1'b0, 3'd1, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{3'd4, 4'd2, 5'h10, 32'h1FFF_FFFC, 4'hF, 32'h0,         1'b0, 3'd1, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{3'd1, 4'd0, 5'h11, 32'h2000_0001, 4'h1, 32'h0000_00AA, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0});

        reset_n = 1'b0; d_ready = 1'b1;
        drive(3'd0, 4'd0, 5'd0, 32'd0, 4'd0, 32'd0, 1'b0);
        a_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("reset d_valid",  32'(d_valid),  32'd0);
        check("reset d_data",   d_data,        32'd0);
        check("reset d_source", 32'(d_source), 32'd0);
        check("reset d_denied", 32'(d_denied), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("reset a_ready", 32'(a_ready), 32'd1);

        foreach (vecs[i]) send(vecs[i], $sformatf("vec%0d", i));
        @(negedge clock);
        check("drain d_valid", 32'(d_valid), 32'd0);

        // Backpressure: first response must hold while d_ready is low, then stream in order.
        d_ready = 1'b0;
        drive(3'd4, 4'd2, 5'd3, 32'h2000_0010, 4'hF, 32'h0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        drive(3'd4, 4'd2, 5'd4, 32'h2000_0010, 4'hF, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check("bp a_ready",  32'(a_ready),  32'd0);
            check("bp d_valid",  32'(d_valid),  32'd1);
            check("bp d_source", 32'(d_source), 32'd3);
            check("bp d_data",   d_data,        32'hDEAD_55EF);
            @(negedge clock);
        end
        d_ready = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("stream d_valid",  32'(d_valid),  32'd1);
            check("stream d_source", 32'(d_source), 32'(k));
            check("stream d_data",   d_data,        32'hDEAD_55EF);
            if (k < 6) drive(3'd4, 4'd2, 5'(k + 1), 32'h2000_0010, 4'hF, 32'h0, 1'b0);
            else a_valid = 1'b0;
        end
        @(negedge clock);
        check("stream end d_valid", 32'(d_valid), 32'd0);

        // Reset while a response is pending.
        d_ready = 1'b0;
        v = '{3'd4, 4'd2, 5'h12, 32'h2000_0000, 4'hF, 32'h0, 1'b0, 3'd1, 1'b0, 1'b0, 32'h1177_3344};
        send(v, "pre-reset");
        #2 reset_n = 1'b0;
        #1;
        check("async reset d_valid", 32'(d_valid), 32'd0);
        check("async reset d_data",  d_data,        32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        d_ready = 1'b1;
        @(negedge clock);
        check("post-reset d_valid", 32'(d_valid), 32'd0);
        check("post-reset a_ready", 32'(a_ready), 32'd1);
        v = '{3'd4, 4'd2, 5'h13, 32'h2000_0010, 4'hF, 32'h0, 1'b0, 3'd1, 1'b0, 1'b0, 32'hDEAD_55EF};
        send(v, "post-reset get");
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
